// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: request/operand/result bundle for the sequential conv MAC.
//   start, image, weight, bias  : request and operands (window buffer -> MAC)
//   in_ready, busy              : MAC status
//   result, out_valid           : result side (MAC -> feature-map writer)
//   out_ready                   : writer accepts the result
// master = requester/consumer side, slave = the MAC unit.
interface conv_mac_seq_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAPS       = 18
);
  logic                       start;
  logic                       in_ready;
  logic [TAPS*DATA_WIDTH-1:0] image;
  logic [TAPS*DATA_WIDTH-1:0] weight;
  logic [DATA_WIDTH-1:0]      bias;
  logic                       busy;
  logic [DATA_WIDTH-1:0]      result;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output start, image, weight, bias, out_ready,
    input  in_ready, busy, result, out_valid
  );

  modport slave (
    input  start, image, weight, bias, out_ready,
    output in_ready, busy, result, out_valid
  );
endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential fp16 3D convolution for one output pixel.
// Captures a C x K_WID x K_LEN window, its weights and a bias on start, then accumulates
// LANES products per cycle in a fixed order and presents the (optionally ReLU'd) sum
// through a valid/ready handshake.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : conv_mac_seq_if.slave (start/in_ready, image/weight/bias, busy,
//            result/out_valid/out_ready)
module conv_mac_seq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_CH      = 2,
  parameter int unsigned K_LEN      = 3,
  parameter int unsigned K_WID      = 3,
  parameter int unsigned LANES      = 1,
  parameter int unsigned RELU_EN    = 0
) (
  input logic           clk,
  input logic           reset,
  conv_mac_seq_if.slave bus
);
  localparam int unsigned TAPS = IN_CH * K_LEN * K_WID;
  localparam int unsigned CW   = $clog2(TAPS) + 1;
  localparam logic [15:0] QNAN = 16'h7E00;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((TAPS % LANES) != 0) begin : g_lanes_check
    $error("conv_mac_seq: LANES must divide IN_CH*K_LEN*K_WID");
  end
  if (DATA_WIDTH != 16) begin : g_width_check
    $error("conv_mac_seq: only fp16 (DATA_WIDTH=16) is supported");
  end

  // ---------------------------------------------------------------- fp16 helpers
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  function automatic logic is_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
  endfunction

  // Subnormals share the exponent of the smallest normal.
  function automatic int eff_exp(input logic [4:0] e);
    return (e == 5'd0) ? 1 : int'(e);
  endfunction

  // Right shift that ORs every bit shifted out into bit 0.
  function automatic logic [31:0] shr_sticky(input logic [31:0] v, input int sh);
    logic [31:0] mask;
    if (sh >= 32) return {31'd0, |v};
    mask = (32'd1 << sh) - 32'd1;
    return (v >> sh) | {31'd0, |(v & mask)};
  endfunction

  // Normalise and round-to-nearest-even. mant has 1.0 at bit 30 for biased exponent exp_in.
  function automatic logic [15:0] round_pack(input logic sign, input int exp_in,
                                             input logic [31:0] mant_in);
    logic [31:0] m;
    logic [11:0] r;
    logic        rnd;
    logic        denorm;
    int          e;
    m      = mant_in;
    e      = exp_in;
    denorm = 1'b0;
    if (m == 32'd0) return {sign, 15'd0};
    if (m[31]) begin
      m = {1'b0, m[31:2], m[1] | m[0]};
      e = e + 1;
    end
    for (int i = 0; i < 31; i++) begin
      if (!m[30]) begin
        m = m << 1;
        e = e - 1;
      end
    end
    if (e < 1) begin
      m      = shr_sticky(m, 1 - e);
      denorm = 1'b1;
    end
    rnd = m[19] & ((|m[18:0]) | m[20]);
    r   = {1'b0, m[30:20]} + {11'd0, rnd};
    // A subnormal that rounds up to 1.0 becomes the smallest normal via r[10].
    if (denorm) return {sign, 4'd0, r[10], r[9:0]};
    if (r[11]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 31) return {sign, 5'h1F, 10'd0};
    return {sign, e[4:0], r[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [10:0] ma;
    logic [10:0] mb;
    logic [21:0] p;
    int          e;
    s = a[15] ^ b[15];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && (b[14:0] == 15'd0)) || (is_inf(b) && (a[14:0] == 15'd0))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 5'h1F, 10'd0};
    ma = {a[14:10] != 5'd0, a[9:0]};
    mb = {b[14:10] != 5'd0, b[9:0]};
    p  = ma * mb;
    e  = eff_exp(a[14:10]) + eff_exp(b[14:10]) - 15;
    return round_pack(s, e, {p, 10'd0});
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] mx;
    logic [31:0] my;
    logic [31:0] m;
    int          ex;
    int          ey;
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    // x carries the larger magnitude and therefore the result sign.
    if (b[14:0] > a[14:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    ex = eff_exp(x[14:10]);
    ey = eff_exp(y[14:10]);
    mx = {1'b0, x[14:10] != 5'd0, x[9:0], 20'd0};
    my = shr_sticky({1'b0, y[14:10] != 5'd0, y[9:0], 20'd0}, ex - ey);
    if (x[15] == y[15]) m = mx + my;
    else                m = mx - my;
    if (m == 32'd0) return {x[15] & y[15], 15'd0};
    return round_pack(x[15], ex, m);
  endfunction

  // ---------------------------------------------------------------- datapath / FSM
  logic [1:0]                 state_q;
  logic [CW-1:0]              tap_q;
  logic [DATA_WIDTH-1:0]      acc_q;
  logic [DATA_WIDTH-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0]      result_q;
  logic                       out_valid_q;
  logic [TAPS*DATA_WIDTH-1:0] img_q;
  logic [TAPS*DATA_WIDTH-1:0] wgt_q;
  logic                       last_tap;
  int                         idx;

  // Lanes are folded left to right so the rounding sequence is fixed.
  always_comb begin
    acc_sum = acc_q;
    idx     = 0;
    for (int l = 0; l < int'(LANES); l++) begin
      idx = int'(tap_q) + l;
      if (idx < int'(TAPS)) begin
        acc_sum = fp_add(acc_sum,
                         fp_mul(img_q[(int'(TAPS) - 1 - idx) * int'(DATA_WIDTH) +: DATA_WIDTH],
                                wgt_q[(int'(TAPS) - 1 - idx) * int'(DATA_WIDTH) +: DATA_WIDTH]));
      end
    end
  end

  assign last_tap = (tap_q == CW'(TAPS - LANES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      img_q       <= '0;
      wgt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            img_q   <= bus.image;
            wgt_q   <= bus.weight;
            acc_q   <= bus.bias;
            tap_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_sum;
          tap_q <= tap_q + CW'(LANES);
          if (last_tap) begin
            result_q    <= ((RELU_EN != 0) && acc_sum[DATA_WIDTH-1]) ? '0 : acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq: directed bench for conv_mac_seq.
// Three instances: u0 (LANES=1), u1 (LANES=3), u2 (LANES=1, RELU_EN=1).
module tb_conv_mac_seq;
  localparam int unsigned TAPS = 18;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  conv_mac_seq_if #(.DATA_WIDTH(16), .TAPS(TAPS)) b0 ();
  conv_mac_seq_if #(.DATA_WIDTH(16), .TAPS(TAPS)) b1 ();
  conv_mac_seq_if #(.DATA_WIDTH(16), .TAPS(TAPS)) b2 ();

  conv_mac_seq #(.LANES(1), .RELU_EN(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  conv_mac_seq #(.LANES(3), .RELU_EN(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
  conv_mac_seq #(.LANES(1), .RELU_EN(1)) u2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Called at a negedge with b0.start already high. Returns edges from the start-sampling
  // edge to out_valid, and the number of sampled cycles with in_ready low.
  task automatic run_b0(input logic scramble, output int lat, output int low);
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
    if (scramble) begin
      b0.image  = '0;
      b0.weight = '0;
      b0.bias   = 16'hFFFF;
    end
    lat = 0;
    low = b0.in_ready ? 0 : 1;
    while (!b0.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!b0.in_ready) low++;
    end
  endtask

  int   lat;
  int   low;
  logic flag;

  initial begin
    b0.start = 0; b0.image = '0; b0.weight = '0; b0.bias = '0; b0.out_ready = 1;
    b1.start = 0; b1.image = '0; b1.weight = '0; b1.bias = '0; b1.out_ready = 1;
    b2.start = 0; b2.image = '0; b2.weight = '0; b2.bias = '0; b2.out_ready = 1;
    reset = 1'b1;
    #2;
    check("rst_in_ready", b0.in_ready, 1);
    check("rst_busy", b0.busy, 0);
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_result", b0.result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // 1. base case: 18 x (1.0 * 1.0) = 18.0
    b0.image = {TAPS{16'h3C00}}; b0.weight = {TAPS{16'h3C00}}; b0.bias = 16'h0000;
    b0.start = 1'b1;
    run_b0(1'b0, lat, low);
    check("base_latency", lat, 18);
    check("base_result", b0.result, 16'h4C80);
    check("base_busy", b0.busy, 1);
    @(negedge clk);
    check("base_valid_one_cycle", b0.out_valid, 0);
    check("base_in_ready_back", b0.in_ready, 1);
    check("base_result_cleared", b0.result, 16'h0000);
    check("base_in_ready_low_cycles", low, 19);

    // 2. operand capture: inputs trashed after the start edge, 18 x 2.0 = 36.0
    b0.image = {TAPS{16'h4000}}; b0.weight = {TAPS{16'h3C00}}; b0.bias = 16'h0000;
    b0.start = 1'b1;
    run_b0(1'b1, lat, low);
    check("capture_latency", lat, 18);
    check("capture_result", b0.result, 16'h5080);
    @(negedge clk);

    // 3. LANES=3 with bias -1.0: -1 + 18 = 17.0 after 6 edges
    b1.image = {TAPS{16'h3C00}}; b1.weight = {TAPS{16'h3C00}}; b1.bias = 16'hBC00;
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("lanes3_latency", lat, 6);
    check("lanes3_result", b1.result, 16'h4C40);
    @(negedge clk);
    check("lanes3_accepted", b1.out_valid, 0);

    // 4. negative sum -18.0: plain on u0, clamped by ReLU on u2
    b0.image = {TAPS{16'h3C00}}; b0.weight = {TAPS{16'hBC00}}; b0.bias = 16'h0000;
    b2.image = {TAPS{16'h3C00}}; b2.weight = {TAPS{16'hBC00}}; b2.bias = 16'h0000;
    b0.start = 1'b1;
    b2.start = 1'b1;
    run_b0(1'b0, lat, low);
    check("neg_result", b0.result, 16'hCC80);
    check("relu_valid", b2.out_valid, 1);
    check("relu_result", b2.result, 16'h0000);
    @(negedge clk);

    // 5. back-pressure: hold result for 10 cycles, start pulses ignored
    b0.image = {TAPS{16'h3C00}}; b0.weight = {TAPS{16'h3C00}}; b0.bias = 16'h0000;
    b0.out_ready = 1'b0;
    b0.start = 1'b1;
    run_b0(1'b0, lat, low);
    check("bp_latency", lat, 18);
    check("bp_result", b0.result, 16'h4C80);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b0.start = 1'b1;
      @(negedge clk);
      if (b0.out_valid !== 1'b1 || b0.result !== 16'h4C80 || b0.in_ready !== 1'b0) flag = 1'b0;
    end
    check("bp_stable", flag, 1);
    b0.out_ready = 1'b1; // start still high in the acceptance cycle
    @(negedge clk);
    b0.start = 1'b0;
    check("bp_accept_valid", b0.out_valid, 0);
    check("bp_accept_result", b0.result, 16'h0000);
    check("bp_start_ignored", b0.in_ready, 1);
    @(negedge clk);

    // 6. reset 5 cycles into MAC aborts; then a fresh run still gives 18.0
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", b0.busy, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", b0.busy, 0);
    check("abort_in_ready", b0.in_ready, 1);
    check("abort_out_valid", b0.out_valid, 0);
    check("abort_result", b0.result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    flag = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (b0.out_valid !== 1'b0) flag = 1'b1;
    end
    check("abort_no_partial", flag, 0);
    b0.start = 1'b1;
    run_b0(1'b0, lat, low);
    check("post_abort_latency", lat, 18);
    check("post_abort_result", b0.result, 16'h4C80);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
